adc_readout_scheduler: RTL and testbench



---
 rtl/adc_readout_scheduler_pkg.sv | 32 +++
 rtl/adc_readout_scheduler_rr_arbiter.sv | 48 ++++
 rtl/adc_readout_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_adc_readout_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_readout_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// adc_sched_pkg
// Shared definitions for the ADC readout scheduler.
//   - bit positions of the fields inside the 32-bit output word
//   - tag nibble used by frame-marker words
//   - idx_w():     index width for an NCH-entry vector (at least 1 bit)
//   - pack_word(): assembles {ovr, 3'b000, chan, 8'h00, sample}
// ---------------------------------------------------------------------------
package adc_sched_pkg;

    localparam int OVR_BIT    = 31;
    localparam int CHAN_LSB   = 24;
    localparam int SAMPLE_LSB = 0;

    localparam logic [3:0] MARKER_TAG = 4'hF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] pack_word(input logic        ovr,
                                              input logic [3:0]  chan,
                                              input logic [15:0] sample);
        logic [31:0] w;
        w                      = '0;
        w[OVR_BIT]             = ovr;
        w[CHAN_LSB +: 4]       = chan;
        w[SAMPLE_LSB +: 16]    = sample;
        return w;
    endfunction

endpackage

// File: rtl/adc_readout_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The channel after the last
// grant has the highest priority; the search wraps modulo NCH.
// Implemented as rotate -> fixed lowest-index priority -> rotate back.
// Ports:
//   req        in   NCH-bit request vector
//   last       in   index of the previously granted channel
//   grant      out  one-hot grant (all zero when nothing requests)
//   grant_idx  out  binary index of the granted channel
//   any_grant  out  at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter int NCH = 16
) (
    input  logic [NCH-1:0]          req,
    input  logic [idx_w(NCH)-1:0]   last,
    output logic [NCH-1:0]          grant,
    output logic [idx_w(NCH)-1:0]   grant_idx,
    output logic                    any_grant
);

    localparam int IW = idx_w(NCH);

    logic [IW-1:0]  start;
    logic [IW-1:0]  rot_idx;
    logic [NCH-1:0] rot;

    always_comb begin
        // NCH is a power of two, so IW-bit arithmetic wraps modulo NCH.
        start     = last + IW'(1);
        rot       = NCH'({req, req} >> start);
        rot_idx   = '0;
        any_grant = 1'b0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx   = IW'(i);
                any_grant = 1'b1;
            end
        end
        grant_idx = rot_idx + start;
        grant     = any_grant ? (NCH'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/adc_readout_scheduler.sv
// ---------------------------------------------------------------------------
// adc_readout_scheduler
// Serialises per-channel ADC samples onto a single 32-bit valid/ready stream.
// A rising edge on adcready[i] (with channel_enable[i]=1) latches channel i's
// signed sample and marks it pending; a round-robin arbiter picks one pending
// channel per output word. A channel that produces a new sample before its
// previous one was sent overwrites it, tags its next word with the ovr bit and
// sets its sticky overrun flag.
//
// Optional feature, macro ADC_SCHED_FRAME_MARKER_EN: periodic frame-marker
// words (32'hF000_0000 | frame_count[23:0]) every update_time cycles, with
// priority over channel words. Without the macro update_time is ignored.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   adcdata          NCH*SW packed samples, channel i at [i*SW +: SW]
//   adcready         per-channel conversion-ready level (rising edge = new)
//   channel_enable   per-channel participation enable
//   update_time      frame-marker period in cycles, 0 = off
//   out_data         {ovr, 3'b000, chan[3:0], 8'h00, sample[15:0]}
//   out_valid        out_data holds a word
//   out_ready        downstream accepts the word
//   overrun          sticky per-channel overrun flags
//   overrun_clear    one-cycle pulse clearing all overrun flags
//
// Handshake: a word transfers on a clock edge where out_valid & out_ready.
// Once out_valid is raised, out_data is held unchanged until that transfer;
// the register reloads on the same edge as a transfer, so back-to-back words
// need no idle cycle.
// ---------------------------------------------------------------------------
module adc_readout_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NCH = 16,
    parameter int SW  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH*SW-1:0]   adcdata,
    input  logic [NCH-1:0]      adcready,
    input  logic [NCH-1:0]      channel_enable,
    input  logic [31:0]         update_time,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NCH-1:0]      overrun,
    input  logic                overrun_clear
);

    localparam int IW = idx_w(NCH);

    logic [NCH-1:0] adcready_d;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] ovr_flag;
    logic [SW-1:0]  sample_reg [NCH];

    logic [NCH-1:0] rise;
    logic [NCH-1:0] req;
    logic [NCH-1:0] grant_oh;
    logic [NCH-1:0] grant_take;
    logic [NCH-1:0] ovr_set;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant_idx;
    logic           any_grant;
    logic           load_en;
    logic           take_chan;
    logic           marker_sel;
    logic [31:0]    marker_word;

    assign rise      = adcready & ~adcready_d & channel_enable;
    // A disabled channel must never win, even in the cycle its pending bit
    // is still waiting to be cleared.
    assign req       = pending & channel_enable;
    assign load_en   = ~out_valid | out_ready;
    assign take_chan = load_en & any_grant & ~marker_sel;
    assign grant_take = take_chan ? grant_oh : '0;
    // A rise on the channel being granted this cycle is a normal refill,
    // not an overrun: the old sample leaves in the word being loaded.
    assign ovr_set   = rise & pending & ~grant_take;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req       (req),
        .last      (rr_ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Sample capture has no reset: a slot is only read after a rise wrote it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rise[i]) begin
                sample_reg[i] <= adcdata[i*SW +: SW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adcready_d <= adcready;
            pending    <= '0;
            ovr_flag   <= '0;
            overrun    <= '0;
        end else begin
            adcready_d <= adcready;
            for (int i = 0; i < NCH; i++) begin
                if (!channel_enable[i]) begin
                    pending[i]  <= 1'b0;
                    ovr_flag[i] <= 1'b0;
                end else if (rise[i]) begin
                    pending[i] <= 1'b1;
                    if (ovr_set[i]) begin
                        ovr_flag[i] <= 1'b1;
                    end else if (grant_take[i]) begin
                        ovr_flag[i] <= 1'b0;
                    end
                end else if (grant_take[i]) begin
                    pending[i]  <= 1'b0;
                    ovr_flag[i] <= 1'b0;
                end
            end
            // Same-cycle set beats the clear.
            overrun <= (overrun & ~{NCH{overrun_clear}}) | ovr_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rr_ptr    <= IW'(NCH - 1);
        end else if (load_en) begin
            if (marker_sel) begin
                out_valid <= 1'b1;
                out_data  <= marker_word;
            end else if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= pack_word(ovr_flag[grant_idx], 4'(grant_idx),
                                       16'($signed(sample_reg[grant_idx])));
                rr_ptr    <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ADC_SCHED_FRAME_MARKER_EN
    logic [31:0] cycle_cnt;
    logic        marker_pending;
    logic [23:0] frame_count;
    logic        expire;
    logic        marker_take;

    // ">=" also recovers when update_time is lowered below the running count.
    assign expire      = (update_time != 32'd0) && (cycle_cnt >= update_time - 32'd1);
    assign marker_take = load_en & marker_pending;
    assign marker_sel  = marker_pending;
    assign marker_word = {MARKER_TAG, 4'h0, frame_count};

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt      <= '0;
            marker_pending <= 1'b0;
            frame_count    <= '0;
        end else begin
            if (update_time == 32'd0) begin
                cycle_cnt      <= '0;
                marker_pending <= 1'b0;
            end else begin
                cycle_cnt <= expire ? 32'd0 : cycle_cnt + 32'd1;
                // An expiry while a marker is still waiting merges into it.
                if (expire) begin
                    marker_pending <= 1'b1;
                end else if (marker_take) begin
                    marker_pending <= 1'b0;
                end
            end
            if (marker_take) begin
                frame_count <= frame_count + 24'd1;
            end
        end
    end
`else
    logic unused_update_time;

    assign unused_update_time = ^update_time;
    assign marker_sel         = 1'b0;
    assign marker_word        = '0;
`endif

endmodule

// File: tb/tb_adc_readout_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_readout_scheduler
// Directed scenarios plus a randomized soak, checked against a
// transaction-level reference model of the scheduler's rules.
// ---------------------------------------------------------------------------
module tb_adc_readout_scheduler;

    localparam int NCH = 16;
    localparam int SW  = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NCH*SW-1:0]   adcdata = '0;
    logic [NCH-1:0]      adcready = '0;
    logic [NCH-1:0]      channel_enable = '1;
    logic [31:0]         update_time = '0;
    logic [31:0]         out_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [NCH-1:0]      overrun;
    logic                overrun_clear = 1'b0;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [SW-1:0]  m_samp [NCH];
    logic [NCH-1:0] m_pend = '0;
    logic [NCH-1:0] m_ovr = '0;
    logic [NCH-1:0] m_overrun = '0;
    logic [NCH-1:0] m_prev = '0;
    int             m_rr = NCH - 1;
    logic           m_valid = 1'b0;
    logic [31:0]    m_data = '0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    adc_readout_scheduler #(
        .NCH (NCH),
        .SW  (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .adcdata        (adcdata),
        .adcready       (adcready),
        .channel_enable (channel_enable),
        .update_time    (update_time),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overrun        (overrun),
        .overrun_clear  (overrun_clear)
    );

    task automatic set_sample(input int ch, input logic [SW-1:0] v);
        adcdata[ch*SW +: SW] = v;
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // then advance the DUT by the same clock and settle past the edge.
    task automatic step();
        logic [NCH-1:0] rise;
        int g;
        bit load;
        if (reset) begin
            m_valid   = 1'b0;
            m_data    = '0;
            m_pend    = '0;
            m_ovr     = '0;
            m_overrun = '0;
            m_rr      = NCH - 1;
            m_prev    = adcready;
        end else begin
            rise = adcready & ~m_prev & channel_enable;
            load = !m_valid || out_ready;
            g = -1;
            if (load) begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_rr + k) % NCH;
                    if (g < 0 && m_pend[c] && channel_enable[c]) g = c;
                end
            end
            if (g >= 0) begin
                m_data  = {m_ovr[g], 3'b000, 4'(g), 8'h00, m_samp[g]};
                m_valid = 1'b1;
                m_rr    = g;
                m_pend[g] = 1'b0;
                m_ovr[g]  = 1'b0;
            end else if (load) begin
                m_valid = 1'b0;
            end
            if (overrun_clear) m_overrun = '0;
            for (int i = 0; i < NCH; i++) begin
                if (!channel_enable[i]) begin
                    m_pend[i] = 1'b0;
                    m_ovr[i]  = 1'b0;
                end else if (rise[i]) begin
                    if (m_pend[i]) begin
                        m_ovr[i]     = 1'b1;
                        m_overrun[i] = 1'b1;
                    end
                    m_samp[i] = adcdata[i*SW +: SW];
                    m_pend[i] = 1'b1;
                end
            end
            m_prev = adcready;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00000000", out_data);
        end
        checks++;
        if (overrun !== '0) begin
            failures++;
            $display("FAIL reset_overrun: got %h expected 0000", overrun);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_edge();
        set_sample(3, 16'hFFD0);
        adcready[3] = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_n1_valid: got %0b expected 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0300_FFD0) begin
            failures++;
            $display("FAIL single_n2_word: got valid=%0b data=%h expected valid=1 data=0300ffd0",
                     out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_n3_valid: got %0b expected 0", out_valid);
        end
        adcready = '0;
        step();
    endtask

    task automatic test_all_channels();
        logic [31:0] w;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            set_sample(i, 16'(16'h0010 * i));
            exp_q.push_back({1'b0, 3'b000, 4'(i), 8'h00, 16'(16'h0010 * i)});
        end
        adcready = '1;
        step();
        step();
        for (int i = 0; i < NCH; i++) begin
            w = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_data !== w) begin
                failures++;
                $display("FAIL burst_word%0d: got valid=%0b data=%h expected valid=1 data=%h",
                         i, out_valid, out_data, w);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL burst_end_valid: got %0b expected 0", out_valid);
        end
        // second burst: order restarts after channel 15, i.e. at 0
        adcready = '0;
        step();
        for (int i = 0; i < NCH; i++) set_sample(i, 16'($urandom));
        adcready = '1;
        step();
        step();
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[27:24] !== 4'(i) || out_data !== m_data) begin
                failures++;
                $display("FAIL burst2_word%0d: got valid=%0b data=%h expected valid=1 data=%h",
                         i, out_valid, out_data, m_data);
            end
            step();
        end
        adcready = '0;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        out_ready = 1'b0;
        set_sample(1, 16'h1111);
        adcready[1] = 1'b1;
        step();
        step();
        set_sample(5, 16'h0A0A);
        adcready[5] = 1'b1;
        step();
        held = 32'h0100_1111;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%0b data=%h expected valid=1 data=%h",
                         i, out_valid, out_data, held);
            end
            step();
        end
        adcready[5] = 1'b0;
        step();
        set_sample(5, 16'hBEEF);
        adcready[5] = 1'b1;
        step();
        checks++;
        if (overrun !== 16'h0020) begin
            failures++;
            $display("FAIL bp_overrun: got %h expected 0020", overrun);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h8500_BEEF) begin
            failures++;
            $display("FAIL bp_ovr_word: got valid=%0b data=%h expected valid=1 data=8500beef",
                     out_valid, out_data);
        end
        step();
        adcready = '0;
        step();
    endtask

    task automatic test_disabled();
        channel_enable[7] = 1'b0;
        adcready[7] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL dis_ch7_word%0d: got valid=%0b data=%h expected valid=0",
                         i, out_valid, out_data);
            end
        end
        channel_enable[7] = 1'b1;
        adcready = '0;
        out_ready = 1'b0;
        step();
        set_sample(0, 16'h0001);
        adcready[0] = 1'b1;
        step();
        step();
        set_sample(2, 16'h0002);
        adcready[2] = 1'b1;
        step();
        channel_enable[2] = 1'b0;
        step();
        channel_enable[2] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (out_valid === 1'b1 && out_data[27:24] === 4'd2) begin
                failures++;
                $display("FAIL dis_ch2_emitted: got data=%h expected no ch2 word", out_data);
            end
        end
        adcready = '0;
        step();
    endtask

    task automatic test_overrun_clear();
        // overrun[5] is still set from the backpressure scenario
        out_ready = 1'b0;
        set_sample(9, 16'h0009);
        adcready[9] = 1'b1;
        step();
        step();
        set_sample(1, 16'h0101);
        adcready[1] = 1'b1;
        step();
        adcready[1] = 1'b0;
        step();
        set_sample(1, 16'h0102);
        adcready[1] = 1'b1;
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        checks++;
        if (overrun !== 16'h0002) begin
            failures++;
            $display("FAIL ovrclr_bits: got %h expected 0002", overrun);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0900_0009) begin
            failures++;
            $display("FAIL ovrclr_held: got valid=%0b data=%h expected valid=1 data=09000009",
                     out_valid, out_data);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_valid: got %0b expected 0", out_valid);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_dropped: got valid=%0b data=%h expected valid=0",
                     out_valid, out_data);
        end
        adcready = '0;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            adcready       = NCH'($urandom);
            adcdata        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            out_ready      = ($urandom_range(0, 3) != 0);
            overrun_clear  = ($urandom_range(0, 15) == 0);
            channel_enable = ($urandom_range(0, 7) == 0) ? ~(NCH'(1) << $urandom_range(0, NCH - 1)) : '1;
            reset          = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if (out_valid !== m_valid || (m_valid && out_data !== m_data) || overrun !== m_overrun) begin
                failures++;
                $display("FAIL random_cycle%0d: got valid=%0b data=%h ovr=%h expected valid=%0b data=%h ovr=%h",
                         n, out_valid, out_data, overrun, m_valid, m_data, m_overrun);
            end
        end
        reset = 1'b0;
        overrun_clear = 1'b0;
        channel_enable = '1;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) m_samp[i] = '0;
        test_reset();
        test_single_edge();
        test_all_channels();
        test_backpressure();
        test_disabled();
        test_overrun_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
